// File: rtl/ioctl_loader.sv
// Packs the mist_io download byte stream into 16-bit words with byte enables and writes them
// to a ROM/RAM controller via req/ack. Optional checksum: define IOCTL_LOADER_CHECKSUM_EN.
module ioctl_loader #(
   parameter int unsigned FIFO_LOG2  = 2,
   parameter logic [7:0]  INDEX_MASK = 8'h1F,
   parameter logic [7:0]  INDEX_SEL  = 8'h00
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_din,
   output logic [1:0]  mem_be,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic [24:0] byte_count,
   output logic        overflow,
   output logic [15:0] checksum
);

   localparam int unsigned Depth = 1 << FIFO_LOG2;

   typedef enum logic [2:0] {StIdle, StActive, StFlush, StDrain, StDone} state_e;

   state_e state_q, state_d;
   logic   dl_q;
   logic   start, accept;

   logic        pend_valid_q, pend_valid_d;
   logic [23:0] pend_addr_q, pend_addr_d;
   logic [15:0] pend_data_q, pend_data_d;
   logic [1:0]  pend_be_q, pend_be_d;

   logic [1:0]  lane_be, merged_be;
   logic [15:0] byte_word, merged_data;

   logic        push, push_ok, drop, pop;
   logic [15:0] push_data;
   logic [1:0]  push_be;

   logic [23:0]        fifo_addr_q [Depth];
   logic [15:0]        fifo_data_q [Depth];
   logic [1:0]         fifo_be_q   [Depth];
   logic [FIFO_LOG2:0] wr_ptr_q, rd_ptr_q;
   logic               fifo_empty, fifo_full;

   logic        mem_req_q, mem_req_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_din_q, mem_din_d;
   logic [1:0]  mem_be_q, mem_be_d;

   logic [24:0] byte_count_q, byte_count_d;
   logic        overflow_q, overflow_d;

   assign start  = (state_q == StIdle) && ioctl_download && !dl_q &&
                   ((ioctl_index & INDEX_MASK) == INDEX_SEL);
   assign accept = (state_q == StActive) && ioctl_wr;

   assign lane_be     = ioctl_addr[0] ? 2'b10 : 2'b01;
   assign byte_word   = ioctl_addr[0] ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
   assign merged_be   = pend_be_q | lane_be;
   assign merged_data = pend_data_q | byte_word;

   // Pending-word assembly; produces at most one FIFO push per cycle.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      pend_be_d    = pend_be_q;
      push         = 1'b0;
      push_data    = pend_data_q;
      push_be      = pend_be_q;
      if (start) begin
         pend_valid_d = 1'b0;
         pend_addr_d  = 24'h0;
         pend_data_d  = 16'h0;
         pend_be_d    = 2'b00;
      end else if (accept) begin
         if (pend_valid_q && (pend_addr_q == ioctl_addr[24:1]) &&
             ((pend_be_q & lane_be) == 2'b00)) begin
            if (merged_be == 2'b11) begin
               push         = 1'b1;
               push_data    = merged_data;
               push_be      = merged_be;
               pend_valid_d = 1'b0;
            end else begin
               pend_data_d = merged_data;
               pend_be_d   = merged_be;
            end
         end else begin
            push         = pend_valid_q;
            pend_valid_d = 1'b1;
            pend_addr_d  = ioctl_addr[24:1];
            pend_data_d  = byte_word;
            pend_be_d    = lane_be;
         end
      end else if (state_q == StFlush) begin
         push         = pend_valid_q;
         pend_valid_d = 1'b0;
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                       (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
   assign pop        = !mem_req_q && !fifo_empty;
   // A full FIFO that pops this cycle frees the slot the push needs.
   assign push_ok    = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         fifo_addr_q[wr_ptr_q[FIFO_LOG2-1:0]] <= pend_addr_q;
         fifo_data_q[wr_ptr_q[FIFO_LOG2-1:0]] <= push_data;
         fifo_be_q[wr_ptr_q[FIFO_LOG2-1:0]]   <= push_be;
      end
   end

   always_comb begin
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_be_d   = mem_be_q;
      if (mem_req_q && mem_ack) begin
         mem_req_d = 1'b0;
      end else if (pop) begin
         mem_req_d  = 1'b1;
         mem_addr_d = fifo_addr_q[rd_ptr_q[FIFO_LOG2-1:0]];
         mem_din_d  = fifo_data_q[rd_ptr_q[FIFO_LOG2-1:0]];
         mem_be_d   = fifo_be_q[rd_ptr_q[FIFO_LOG2-1:0]];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StActive;
         StActive: if (!ioctl_download) state_d = StFlush;
         StFlush:  state_d = StDrain;
         StDrain:  if (fifo_empty && !mem_req_q) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      byte_count_d = byte_count_q;
      overflow_d   = overflow_q;
      if (start) begin
         byte_count_d = 25'h0;
         overflow_d   = 1'b0;
      end else begin
         if (accept) byte_count_d = byte_count_q + 25'd1;
         if (drop)   overflow_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         dl_q         <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= 24'h0;
         pend_data_q  <= 16'h0;
         pend_be_q    <= 2'b00;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 24'h0;
         mem_din_q    <= 16'h0;
         mem_be_q     <= 2'b00;
         byte_count_q <= 25'h0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         dl_q         <= ioctl_download;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         pend_be_q    <= pend_be_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + {{FIFO_LOG2{1'b0}}, 1'b1};
         if (pop)     rd_ptr_q <= rd_ptr_q + {{FIFO_LOG2{1'b0}}, 1'b1};
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         mem_be_q     <= mem_be_d;
         byte_count_q <= byte_count_d;
         overflow_q   <= overflow_d;
      end
   end

`ifdef IOCTL_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         checksum_q <= 16'h0;
      end else if (start) begin
         checksum_q <= 16'h0;
      end else if (accept) begin
         checksum_q <= checksum_q + {8'h00, ioctl_dout};
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'h0000;
`endif

   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign mem_be     = mem_be_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign byte_count = byte_count_q;
   assign overflow   = overflow_q;

endmodule
